// File: rtl/mips_irq_pkg.sv
// Shared types and defaults for the MIPS interrupt controller and its helpers.
package mips_irq_pkg;

    localparam int unsigned NUM_IRQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PENDING,
        IRQ_SERVICE
    } irq_state_e;

    // Vector width for n lines, never below one bit.
    function automatic int unsigned vec_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mips_irq_ctrl_if.sv
// Core-side interrupt handshake: request/vector/in-service out, ack/eret back.
interface mips_irq_ctrl_if #(
    parameter int unsigned VEC_W = 3
);
    logic             cpu_int;
    logic [VEC_W-1:0] cpu_vec;
    logic             in_service;
    logic             int_ack;
    logic             eret;

    modport master (
        output cpu_int, cpu_vec, in_service,
        input  int_ack, eret
    );

    modport slave (
        input  cpu_int, cpu_vec, in_service,
        output int_ack, eret
    );
endinterface

// File: rtl/mips_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; combinational.
module irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned VEC_W   = 3
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any,
    output logic [VEC_W-1:0]   idx
);
    always_comb begin
        any = |req;
        idx = '0;
        // Scan downward so the lowest requesting index is written last.
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (req[i-1]) idx = VEC_W'(i - 1);
        end
    end
endmodule

// File: rtl/mips_irq_ctrl.sv
// Interrupt controller in front of mips_cpu.int0: sync, pending, priority, FSM.
module mips_irq_ctrl
    import mips_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int unsigned VEC_W   = vec_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [NUM_IRQ-1:0] edge_mode,
    output logic [NUM_IRQ-1:0] irq_pending,
    mips_irq_ctrl_if.master    cpu
);
    logic [NUM_IRQ-1:0] s1, s2, s3;
    logic [NUM_IRQ-1:0] pend, pend_next, rise, ack_clr, eligible;
    logic [VEC_W-1:0]   vec_q, vec_next, top_idx;
    logic               any_eligible, ack_take, int_q, svc_q;
    irq_state_e         state, state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign ack_take = (state == IRQ_PENDING) && cpu.int_ack;

    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = ack_take && (VEC_W'(i) == vec_q);
        end
    end

    // Edge lines: a new rise overrides an ack clear. Level lines just follow s2.
    assign pend_next = (edge_mode & (rise | (pend & ~ack_clr))) | (~edge_mode & s2);
    assign eligible  = pend & irq_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend <= '0;
        else      pend <= pend_next;
    end

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .VEC_W   (VEC_W)
    ) u_prio_enc (
        .req (eligible),
        .any (any_eligible),
        .idx (top_idx)
    );

    always_comb begin
        state_next = state;
        vec_next   = vec_q;
        unique case (state)
            IRQ_IDLE: begin
                if (any_eligible) begin
                    state_next = IRQ_PENDING;
                    vec_next   = top_idx;
                end
            end
            IRQ_PENDING: begin
                if (cpu.int_ack)            state_next = IRQ_SERVICE;
                else if (!eligible[vec_q])  state_next = IRQ_IDLE;
            end
            IRQ_SERVICE: begin
                if (cpu.eret) state_next = IRQ_IDLE;
            end
            default: state_next = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IRQ_IDLE;
            vec_q <= '0;
            int_q <= 1'b0;
            svc_q <= 1'b0;
        end else begin
            state <= state_next;
            vec_q <= vec_next;
            int_q <= (state_next == IRQ_PENDING);
            svc_q <= (state_next == IRQ_SERVICE);
        end
    end

    assign cpu.cpu_int    = int_q;
    assign cpu.cpu_vec    = vec_q;
    assign cpu.in_service = svc_q;
    assign irq_pending    = pend;

endmodule

// File: tb/tb_mips_irq_ctrl.sv
// Directed bench for mips_irq_ctrl: reset, latency, priority, mask, level, collision.
module tb_mips_irq_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] irq_in, irq_mask, edge_mode, irq_pending;
    int         passed = 0;
    int         total  = 0;

    mips_irq_ctrl_if #(.VEC_W(3)) cpu_bus ();

    mips_irq_ctrl #(.NUM_IRQ(8), .VEC_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .edge_mode   (edge_mode),
        .irq_pending (irq_pending),
        .cpu         (cpu_bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        cpu_bus.int_ack = 1'b1;
        step();
        cpu_bus.int_ack = 1'b0;
    endtask

    task automatic eret_pulse();
        cpu_bus.eret = 1'b1;
        step();
        cpu_bus.eret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_in = '0; irq_mask = 8'hFF; edge_mode = 8'hFF;
        cpu_bus.int_ack = 1'b0; cpu_bus.eret = 1'b0;
        step(2);
        total++;
        if (cpu_bus.cpu_int !== 1'b0 || cpu_bus.cpu_vec !== 3'd0 || cpu_bus.in_service !== 1'b0 || irq_pending !== 8'h00)
            $display("FAIL reset_state: int=%b vec=%0d svc=%b pend=%h, want 0/0/0/00", cpu_bus.cpu_int, cpu_bus.cpu_vec, cpu_bus.in_service, irq_pending);
        else passed++;
        rst = 1'b1;
        irq_in[2] = 1'b1;
        step(4);
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd2)
            $display("FAIL reset_pre_pending: int=%b vec=%0d, want 1/2", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if (cpu_bus.cpu_int !== 1'b0 || cpu_bus.cpu_vec !== 3'd0 || cpu_bus.in_service !== 1'b0 || irq_pending !== 8'h00)
            $display("FAIL reset_async: int=%b vec=%0d svc=%b pend=%h, want 0/0/0/00", cpu_bus.cpu_int, cpu_bus.cpu_vec, cpu_bus.in_service, irq_pending);
        else passed++;
        irq_in = '0;
        step();
        rst = 1'b1;
        step(5);
        total++;
        if (cpu_bus.cpu_int !== 1'b0 || irq_pending !== 8'h00)
            $display("FAIL reset_release: int=%b pend=%h, want 0/00", cpu_bus.cpu_int, irq_pending);
        else passed++;
    endtask

    task automatic test_single_edge();
        irq_in[3] = 1'b1;
        step(3);
        total++;
        if (irq_pending !== 8'h08 || cpu_bus.cpu_int !== 1'b0)
            $display("FAIL edge_e3: pend=%h int=%b, want 08/0", irq_pending, cpu_bus.cpu_int);
        else passed++;
        step();
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd3)
            $display("FAIL edge_e4: int=%b vec=%0d, want 1/3", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        ack_pulse();
        total++;
        if (cpu_bus.cpu_int !== 1'b0 || irq_pending[3] !== 1'b0 || cpu_bus.in_service !== 1'b1)
            $display("FAIL edge_ack: int=%b pend3=%b svc=%b, want 0/0/1", cpu_bus.cpu_int, irq_pending[3], cpu_bus.in_service);
        else passed++;
        ack_pulse();
        total++;
        if (cpu_bus.in_service !== 1'b1)
            $display("FAIL ack_in_service_ignored: svc=%b, want 1", cpu_bus.in_service);
        else passed++;
        eret_pulse();
        total++;
        if (cpu_bus.in_service !== 1'b0 || cpu_bus.cpu_int !== 1'b0)
            $display("FAIL edge_eret: svc=%b int=%b, want 0/0", cpu_bus.in_service, cpu_bus.cpu_int);
        else passed++;
        irq_in[3] = 1'b0;
        eret_pulse();
        step(3);
        total++;
        if (cpu_bus.cpu_int !== 1'b0 || cpu_bus.in_service !== 1'b0)
            $display("FAIL idle_quiet: int=%b svc=%b, want 0/0", cpu_bus.cpu_int, cpu_bus.in_service);
        else passed++;
    endtask

    task automatic test_priority();
        irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        step(4);
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd2)
            $display("FAIL prio_pair: int=%b vec=%0d, want 1/2", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        ack_pulse();
        eret_pulse();
        step();
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd5)
            $display("FAIL prio_second: int=%b vec=%0d, want 1/5", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        ack_pulse();
        eret_pulse();
        irq_in = '0;
        step(4);
        irq_in[5] = 1'b1;
        step(4);
        irq_in[1] = 1'b1;
        step(4);
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd5 || irq_pending[1] !== 1'b1)
            $display("FAIL no_preempt: int=%b vec=%0d pend1=%b, want 1/5/1", cpu_bus.cpu_int, cpu_bus.cpu_vec, irq_pending[1]);
        else passed++;
        ack_pulse();
        eret_pulse();
        total++;
        if (cpu_bus.cpu_int !== 1'b0)
            $display("FAIL idle_gap: int=%b, want 0", cpu_bus.cpu_int);
        else passed++;
        step();
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd1)
            $display("FAIL served_next: int=%b vec=%0d, want 1/1", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        ack_pulse();
        eret_pulse();
        irq_in = '0;
        step(4);
    endtask

    task automatic test_mask_retract();
        edge_mode[4] = 1'b0;
        irq_in[4] = 1'b1;
        step(4);
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd4)
            $display("FAIL level_req: int=%b vec=%0d, want 1/4", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        irq_mask[4] = 1'b0;
        step();
        total++;
        if (cpu_bus.cpu_int !== 1'b0 || irq_pending[4] !== 1'b1 || cpu_bus.in_service !== 1'b0)
            $display("FAIL retract: int=%b pend4=%b svc=%b, want 0/1/0", cpu_bus.cpu_int, irq_pending[4], cpu_bus.in_service);
        else passed++;
        // An ack in IDLE must not start a service period.
        ack_pulse();
        total++;
        if (cpu_bus.in_service !== 1'b0 || cpu_bus.cpu_int !== 1'b0)
            $display("FAIL ack_idle_ignored: svc=%b int=%b, want 0/0", cpu_bus.in_service, cpu_bus.cpu_int);
        else passed++;
        irq_mask[4] = 1'b1;
        step();
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd4)
            $display("FAIL unmask: int=%b vec=%0d, want 1/4", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        ack_pulse();
        irq_in[4] = 1'b0;
        step(4);
        eret_pulse();
        step(2);
        edge_mode[4] = 1'b1;
    endtask

    task automatic test_level_persist();
        edge_mode[0] = 1'b0;
        irq_in[0] = 1'b1;
        step(4);
        ack_pulse();
        total++;
        if (irq_pending[0] !== 1'b1 || cpu_bus.in_service !== 1'b1)
            $display("FAIL level_ack_keep: pend0=%b svc=%b, want 1/1", irq_pending[0], cpu_bus.in_service);
        else passed++;
        eret_pulse();
        total++;
        if (cpu_bus.in_service !== 1'b0 || cpu_bus.cpu_int !== 1'b0)
            $display("FAIL level_eret: svc=%b int=%b, want 0/0", cpu_bus.in_service, cpu_bus.cpu_int);
        else passed++;
        step();
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd0)
            $display("FAIL level_resignal: int=%b vec=%0d, want 1/0", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        ack_pulse();
        irq_in[0] = 1'b0;
        step(4);
        eret_pulse();
        step(2);
        edge_mode[0] = 1'b1;
    endtask

    task automatic test_back_to_back();
        irq_in[6] = 1'b1;
        step(4);
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd6)
            $display("FAIL coll_req: int=%b vec=%0d, want 1/6", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        irq_in[6] = 1'b0;
        step(3);
        irq_in[6] = 1'b1;
        step(2);
        // The rise reaches the pending logic on the same edge that samples ack.
        ack_pulse();
        total++;
        if (irq_pending[6] !== 1'b1 || cpu_bus.in_service !== 1'b1 || cpu_bus.cpu_int !== 1'b0)
            $display("FAIL set_wins: pend6=%b svc=%b int=%b, want 1/1/0", irq_pending[6], cpu_bus.in_service, cpu_bus.cpu_int);
        else passed++;
        eret_pulse();
        step();
        total++;
        if (cpu_bus.cpu_int !== 1'b1 || cpu_bus.cpu_vec !== 3'd6)
            $display("FAIL coll_reserve: int=%b vec=%0d, want 1/6", cpu_bus.cpu_int, cpu_bus.cpu_vec);
        else passed++;
        ack_pulse();
        eret_pulse();
        irq_in = '0;
        step(4);
        total++;
        if (cpu_bus.cpu_int !== 1'b0 || irq_pending !== 8'h00)
            $display("FAIL final_idle: int=%b pend=%h, want 0/00", cpu_bus.cpu_int, irq_pending);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_mask_retract();
        test_level_persist();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
